// File: rtl/grant_decoder.sv
// -----------------------------------------------------------------------------
// grant_decoder
//
// Registered 3-to-8 grant decoder with a hold/release FSM. This is the return
// path for an 8-to-3 priority encoder.
//
// The block takes the encoded winner index (n) and the valid flag (g). It
// drives a one-hot grant to the winning requester and holds it until one of
// three things happens: the requester drops its raw request line, the block
// is disabled, or the hold limit expires.
//
// Every grant is followed by a single GAP cycle. The encoder can re-arbitrate
// on fresh request lines during that cycle before the next grant is sampled.
//
// Handshake: a grant is issued when ena & g is sampled high in IDLE. The
// requester owns gnt for as long as req[idx] stays high, up to HOLD_MAX
// cycles. Dropping req[idx] is the requester's release. gnt changes only on
// a clock edge, or when reset is asserted.
//
// Parameters
//   HOLD_MAX      maximum consecutive grant cycles (1..255)
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active-high
//   ena           block enable; low forces release and blocks new grants
//   n[2:0]        encoded winner index from the priority encoder
//   g             encoder valid (at least one request active)
//   req[7:0]      raw request lines, used for release detection
//   gnt[7:0]      registered one-hot grant, zero when no grant is held
//   idx[2:0]      registered index of the current or last grant
//   busy          high while in GRANT or GAP
//   timeout       one-cycle pulse after a grant is revoked by the hold limit
//   dbg_state_o   current FSM state, for observation
// -----------------------------------------------------------------------------
module grant_decoder #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [2:0] n,
   input  logic       g,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] idx,
   output logic       busy,
   output logic       timeout,
   output logic [1:0] dbg_state_o
);

   localparam int CW = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      gnt_q, gnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            timeout_q, timeout_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         gnt_q     <= 8'h00;
         idx_q     <= 3'd0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            gnt_d = 8'h00;
            if (ena && g) begin
               idx_d   = n;
               gnt_d   = 8'b0000_0001 << n;
               cnt_d   = ONE_C;
               state_d = S_GRANT;
            end
         end

         S_GRANT: begin
            // Disable first, then release, then the limit. A release on the
            // limit cycle is therefore a normal release, with no timeout.
            if (!ena) begin
               gnt_d   = 8'h00;
               state_d = S_GAP;
            end else if (!req[idx_q]) begin
               gnt_d   = 8'h00;
               state_d = S_GAP;
            end else if (cnt_q == HOLD_C) begin
               gnt_d     = 8'h00;
               timeout_d = 1'b1;
               state_d   = S_GAP;
            end else begin
               cnt_d = cnt_q + ONE_C;
            end
         end

         S_GAP: begin
            gnt_d   = 8'h00;
            state_d = S_IDLE;
         end

         default: begin
            gnt_d   = 8'h00;
            state_d = S_IDLE;
         end
      endcase
   end

   assign gnt         = gnt_q;
   assign idx         = idx_q;
   assign busy        = (state_q != S_IDLE);
   assign timeout     = timeout_q;
   assign dbg_state_o = state_q;

endmodule
